uart_tx_scheduler: RTL and testbench

- Shares one UART transmitter (bit-serial, one 8N1 frame per start pulse) between N byte-stream requesters.
- Round-robin arbitration at packet granularity: a grant holds until the requester marks its last byte or the MAX_BURST byte limit is reached.
- Sequences the transmitter through a start/busy handshake.
- Sits between client logic (command responders, debug taps) and the UART TX datapath.

---
 rtl/uart_tx_scheduler.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-granular scheduler that shares one 8N1 UART transmitter among N byte streams.
// Optional feature: define UART_SCHED_TAG_EN to prefix every grant with a tag byte {4'hA, 1'b0, id}.
module uart_tx_scheduler #(
  parameter int N          = 4,
  parameter int MAX_BURST  = 16,
  parameter int START_WAIT = 4
) (
  input  logic           clk,
  input  logic           i_reset_n,
  input  logic [N-1:0]   i_req,
  input  logic [8*N-1:0] i_data,
  input  logic [N-1:0]   i_last,
  output logic [N-1:0]   o_ack,
  output logic [N-1:0]   o_grant,
  output logic [7:0]     o_tx_data,
  output logic           o_tx_start,
  input  logic           i_tx_busy,
  output logic           o_err
);

  localparam int         IW        = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);
  localparam logic [3:0] WAIT_LAST = 4'(START_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAG,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    burst_q, burst_d;
  logic          tx_start_q, tx_start_d;
  logic          err_q, err_d;
  logic          last_q, last_d;
  logic [3:0]    wcnt_q, wcnt_d;
`ifdef UART_SCHED_TAG_EN
  logic          tag_q, tag_d;
`endif

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] scan_idx;
  logic [7:0]    sel_data;
  logic          frame_done;

  // Round-robin pick: first set request strictly after the pointer, wrapping around.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      scan_idx = IW'((int'(ptr_q) + i) % N);
      if (!pick_valid && i_req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign sel_data = i_data[{gidx_q, 3'b000} +: 8];

  always_comb begin
    // NOTE: every _d defaults to its _q (or idle value) first, so no path through the case infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    burst_d    = burst_q;
    err_d      = err_q;
    last_d     = last_q;
    wcnt_d     = wcnt_q;
    frame_done = 1'b0;
`ifdef UART_SCHED_TAG_EN
    tag_d      = tag_q;
`endif

    case (state_q)
      S_IDLE: begin
        burst_d = '0;
        // A frame still running from before a reset must finish before anything new starts.
        if (pick_valid && !i_tx_busy) begin
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
`ifdef UART_SCHED_TAG_EN
          state_d           = S_TAG;
`else
          state_d           = S_LOAD;
`endif
        end
      end
`ifdef UART_SCHED_TAG_EN
      S_TAG: begin
        tx_data_d  = {4'hA, 1'b0, 3'(gidx_q)};
        tx_start_d = 1'b1;
        tag_d      = 1'b1;
        wcnt_d     = '0;
        state_d    = S_WAIT_BUSY;
      end
`endif
      S_LOAD: begin
        if (i_req[gidx_q]) begin
          tx_data_d     = sel_data;
          last_d        = i_last[gidx_q];
          ack_d[gidx_q] = 1'b1;
          tx_start_d    = 1'b1;
          burst_d       = burst_q + 8'd1;
          wcnt_d        = '0;
          state_d       = S_WAIT_BUSY;
        end else begin
          grant_d = '0;
          ptr_d   = gidx_q;
          state_d = S_IDLE;
        end
      end
      S_WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (wcnt_q == WAIT_LAST) begin
          err_d      = 1'b1;
          frame_done = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) frame_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_done) begin
`ifdef UART_SCHED_TAG_EN
      if (tag_q) begin
        tag_d   = 1'b0;
        state_d = S_LOAD;
      end else
`endif
      if (last_q || burst_q == BURST_MAX) begin
        ptr_d   = gidx_q;
        grant_d = '0;
        state_d = S_IDLE;
      end else begin
        state_d = S_LOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= IW'(N - 1);
      gidx_q     <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_data_q  <= 8'hFF;
      burst_q    <= '0;
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= 1'b0;
      wcnt_q     <= '0;
`ifdef UART_SCHED_TAG_EN
      tag_q      <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking updates, so every flop samples the pre-edge values computed above.
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      tx_data_q  <= tx_data_d;
      burst_q    <= burst_d;
      tx_start_q <= tx_start_d;
      err_q      <= err_d;
      last_q     <= last_d;
      wcnt_q     <= wcnt_d;
`ifdef UART_SCHED_TAG_EN
      tag_q      <= tag_d;
`endif
    end
  end

  assign o_ack      = ack_q;
  assign o_grant    = grant_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table, directed corner sequences, and
// randomized packet streams checked against a queue-based round-robin service-order model.
module tb_uart_tx_scheduler;

  localparam int N          = 4;
  localparam int MAX_BURST  = 16;
  localparam int START_WAIT = 4;

  logic           clk = 1'b0;
  logic           i_reset_n = 1'b0;
  logic [N-1:0]   i_req = '0;
  logic [8*N-1:0] i_data = '0;
  logic [N-1:0]   i_last = '0;
  logic           i_tx_busy = 1'b0;
  logic [N-1:0]   o_ack;
  logic [N-1:0]   o_grant;
  logic [7:0]     o_tx_data;
  logic           o_tx_start;
  logic           o_err;

  uart_tx_scheduler #(.N(N), .MAX_BURST(MAX_BURST), .START_WAIT(START_WAIT)) dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .i_req      (i_req),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_ack      (o_ack),
    .o_grant    (o_grant),
    .o_tx_data  (o_tx_data),
    .o_tx_start (o_tx_start),
    .i_tx_busy  (i_tx_busy),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] data; logic last; } rbyte_t;
  typedef struct packed { logic [1:0] id; logic [7:0] data; } xfer_t;
  typedef struct packed {
    logic [3:0]      req;
    logic [3:0]      twice;
    logic [2:0]      n;
    logic [3:0][1:0] order;
  } vec_t;

  rbyte_t rq [N][$];
  rbyte_t mq [N][$];
  xfer_t  obs[$];
  xfer_t  exp_q[$];
  int     start_ticks[$];
  int     tests = 0, fails = 0, cyc = 0, ack_cnt = 0;
  int     busy_len = 3, busy_cnt = 0, model_ptr = N - 1;
  bit     tx_dead = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        i_req[k]          = 1'b1;
        i_data[8*k +: 8]  = rq[k][0].data;
        i_last[k]         = rq[k][0].last;
      end else begin
        i_req[k]          = 1'b0;
        i_data[8*k +: 8]  = 8'h00;
        i_last[k]         = 1'b0;
      end
    end
  endtask

  // One cycle: sample outputs at the falling edge, then advance transmitter and requester models.
  task automatic tick();
    int id;
    @(negedge clk);
    cyc++;
    if (o_ack != '0) begin
      ack_cnt++;
      check("ack_with_start", 32'(o_tx_start), 1);
      for (int k = 0; k < N; k++)
        if (o_ack[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    end
    if (o_tx_start) begin
      start_ticks.push_back(cyc);
      id = 0;
      for (int k = 0; k < N; k++) if (o_grant[k]) id = k;
      if (o_ack == '0) begin
`ifdef UART_SCHED_TAG_EN
        check("tag_byte", 32'(o_tx_data), 32'({4'hA, 1'b0, 3'(id)}));
`else
        check("start_has_ack", 32'(o_ack), 32'(o_grant));
`endif
      end else begin
        check("ack_matches_grant", 32'(o_ack), 32'(o_grant));
        obs.push_back('{id: 2'(id), data: o_tx_data});
      end
      if (!tx_dead) begin
        i_tx_busy = 1'b1;
        busy_cnt  = busy_len;
      end
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) i_tx_busy = 1'b0;
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset_n = 1'b0;
    for (int k = 0; k < N; k++) rq[k].delete();
    obs.delete();
    i_tx_busy = 1'b0;
    busy_cnt  = 0;
    tx_dead   = 1'b0;
    ack_cnt   = 0;
    drive_inputs();
    @(negedge clk);
    i_reset_n = 1'b1;
    model_ptr = N - 1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && (i_tx_busy || o_grant != '0); t++) tick();
    tick();
  endtask

  // Service order from the rules alone: next pending requester after the pointer serves
  // until its packet ends or MAX_BURST bytes, then the pointer moves to it.
  task automatic build_expected();
    int     k, cnt;
    bit     found;
    rbyte_t b;
    exp_q.delete();
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    k = 0;
    while (1) begin
      found = 1'b0;
      for (int i = 1; i <= N && !found; i++) begin
        k = (model_ptr + i) % N;
        if (mq[k].size() > 0) found = 1'b1;
      end
      if (!found) break;
      cnt = 0;
      do begin
        b = mq[k].pop_front();
        exp_q.push_back('{id: 2'(k), data: b.data});
        cnt++;
      end while (!b.last && cnt < MAX_BURST && mq[k].size() > 0);
      model_ptr = k;
    end
  endtask

  task automatic run_model_check(input string name);
    build_expected();
    obs.delete();
    drive_inputs();
    for (int t = 0; t < 6000 && obs.size() < exp_q.size(); t++) tick();
    check({name, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      check({name, "_id"}, 32'(obs[i].id), 32'(exp_q[i].id));
      check({name, "_data"}, 32'(obs[i].data), 32'(exp_q[i].data));
    end
    drain();
  endtask

  task automatic rand_round();
    int np, len;
    busy_len = $urandom_range(1, 4);
    for (int k = 0; k < N; k++) begin
      np = $urandom_range(0, 3);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++) rq[k].push_back('{data: 8'($urandom), last: (b == len - 1)});
      end
    end
    run_model_check("rnd");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   s, n0, tfall, pc [N];
    bit   fell, prev;

    // Arbitration vectors run back to back from reset so the pointer carries between them.
    vecs[0] = '{req: 4'b1101, twice: 4'b0001, n: 3'd4, order: {2'd0, 2'd3, 2'd2, 2'd0}};
    vecs[1] = '{req: 4'b0110, twice: 4'b0000, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
    vecs[2] = '{req: 4'b1001, twice: 4'b1000, n: 3'd3, order: {2'd0, 2'd3, 2'd0, 2'd3}};
    vecs[3] = '{req: 4'b1111, twice: 4'b0000, n: 3'd4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
    vecs[4] = '{req: 4'b0100, twice: 4'b0100, n: 3'd2, order: {2'd0, 2'd0, 2'd2, 2'd2}};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_grant", 32'(o_grant), 0);
    check("rst_ack", 32'(o_ack), 0);
    check("rst_start", 32'(o_tx_start), 0);
    check("rst_data", 32'(o_tx_data), 32'hFF);
    check("rst_err", 32'(o_err), 0);
    i_reset_n = 1'b1;

    // Single byte from requester 1, transmitter busy for 3 cycles
    do_reset();
    busy_len = 3;
    rq[1].push_back('{data: 8'h55, last: 1'b1});
    drive_inputs();
    tick();
    check("A_no_early_start", 32'(o_tx_start), 0);
    check("A_grant", 32'(o_grant), 32'b0010);
    tick();
    check("A_start_latency", 32'(o_tx_start), 1);
`ifdef UART_SCHED_TAG_EN
    check("A_first_byte", 32'(o_tx_data), 32'hA1);
`else
    check("A_first_byte", 32'(o_tx_data), 32'h55);
`endif
    fell = 1'b0;
    for (int t = 0; t < 20 && !fell; t++) begin
      prev = i_tx_busy;
      tick();
      if (prev && !i_tx_busy && obs.size() >= 1) fell = 1'b1;
    end
    check("A_busy_fall_seen", 32'(fell), 1);
    check("A_grant_held", 32'(o_grant), 32'b0010);
    tick();
    check("A_grant_release", 32'(o_grant), 0);
    for (int t = 0; t < 14; t++) tick();
    check("A_ack_count", ack_cnt, 1);
    check("A_bytes", obs.size(), 1);
    if (obs.size() > 0) check("A_data", 32'(obs[0].data), 32'h55);

    // Table of simultaneous-request vectors
    do_reset();
    busy_len = 2;
    for (int e = 0; e < 5; e++) begin
      obs.delete();
      for (int k = 0; k < N; k++) begin
        pc[k] = 0;
        if (vecs[e].req[k]) rq[k].push_back('{data: 8'(e*16 + k), last: 1'b1});
        if (vecs[e].twice[k]) rq[k].push_back('{data: 8'(e*16 + 8 + k), last: 1'b1});
      end
      drive_inputs();
      for (int t = 0; t < 200 && obs.size() < int'(vecs[e].n); t++) tick();
      check("vec_count", obs.size(), 32'(vecs[e].n));
      for (int i = 0; i < int'(vecs[e].n) && i < obs.size(); i++) begin
        check("vec_order", 32'(obs[i].id), 32'(vecs[e].order[i]));
        check("vec_data", 32'(obs[i].data), 32'(8'(e*16 + pc[obs[i].id]*8 + int'(obs[i].id))));
        pc[obs[i].id]++;
      end
      drain();
    end

    // 20-byte packet from 0 against a pending 2-byte packet from 1: forced rotation at MAX_BURST
    do_reset();
    busy_len = 2;
    for (int b = 0; b < 20; b++) rq[0].push_back('{data: 8'(8'h80 + b), last: (b == 19)});
    for (int b = 0; b < 2; b++) rq[1].push_back('{data: 8'(8'h40 + b), last: (b == 1)});
    run_model_check("B");
    if (obs.size() > 18) begin
      check("B_rotate_at_burst", 32'(obs[16].id), 1);
      check("B_resume_after", 32'(obs[18].id), 0);
    end

    // Dead transmitter: timeout sets the sticky error and releases the grant
    do_reset();
    tx_dead = 1'b1;
    rq[1].push_back('{data: 8'h11, last: 1'b1});
    rq[2].push_back('{data: 8'h22, last: 1'b1});
    drive_inputs();
    n0 = start_ticks.size();
    for (int t = 0; t < 20 && start_ticks.size() == n0; t++) tick();
    check("C_start_seen", 32'(start_ticks.size() > n0), 1);
    s = cyc;
    while (cyc < s + START_WAIT - 1) tick();
    check("C_err_before_timeout", 32'(o_err), 0);
    tick();
    check("C_err_at_timeout", 32'(o_err), 1);
`ifndef UART_SCHED_TAG_EN
    check("C_grant_released", 32'(o_grant), 0);
`endif
    for (int t = 0; t < 80 && obs.size() < 2; t++) tick();
    check("C_both_served", obs.size(), 2);
    if (obs.size() > 1) begin
      check("C_first_owner", 32'(obs[0].id), 1);
      check("C_next_served", 32'(obs[1].id), 2);
    end
    tx_dead = 1'b0;
    busy_len = 2;
    rq[3].push_back('{data: 8'h33, last: 1'b1});
    drive_inputs();
    for (int t = 0; t < 40 && obs.size() < 3; t++) tick();
    drain();
    check("C_err_sticky", 32'(o_err), 1);

    // Reset during WAIT_DONE with the transmitter still busy
    do_reset();
    busy_len = 10;
    rq[3].push_back('{data: 8'h77, last: 1'b1});
    drive_inputs();
    n0 = start_ticks.size();
    for (int t = 0; t < 20 && start_ticks.size() == n0; t++) tick();
    for (int t = 0; t < 3; t++) tick();
    i_reset_n = 1'b0;
    #1;
    check("D_busy_at_reset", 32'(i_tx_busy), 1);
    check("D_grant_cleared", 32'(o_grant), 0);
    check("D_start_cleared", 32'(o_tx_start), 0);
    check("D_data_reset", 32'(o_tx_data), 32'hFF);
    check("D_ack_cleared", 32'(o_ack), 0);
    for (int k = 0; k < N; k++) rq[k].delete();
    drive_inputs();
    tick();
    i_reset_n = 1'b1;
    rq[0].push_back('{data: 8'hD0, last: 1'b1});
    drive_inputs();
    n0 = start_ticks.size();
    for (int t = 0; t < 30 && i_tx_busy; t++) tick();
    tfall = cyc;
    check("D_no_start_while_busy", start_ticks.size(), n0);
    for (int t = 0; t < 10 && start_ticks.size() == n0; t++) tick();
    check("D_start_seen", 32'(start_ticks.size() > n0), 1);
    if (start_ticks.size() > n0) check("D_start_after_busy", start_ticks[n0], tfall + 2);
    drain();

    // Randomized packet streams against the service-order model
    do_reset();
    for (int r = 0; r < 6; r++) rand_round();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
